pipelined_select_subtractor: RTL and testbench
==============================================

// Module: pipelined_select_subtractor
// PURPOSE
//  Two-stage pipelined WIDTH-bit subtractor D = A - B - bin.
//  Carry-select split at WIDTH/2: stage 1 resolves the low half and both
//  high-half candidates; stage 2 picks the high half by the low-half carry.
//  Valid/ready handshake on input and output; feeds compare/branch and
//  address-offset logic next to the existing combinational adders.
// PARAMETERS
//  WIDTH  32  operand width; even, >= 4; split point H = WIDTH/2
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      A, B, bin valid this cycle
//  in_ready   out  1      block accepts operands this cycle
//  A          in   WIDTH  minuend
//  B          in   WIDTH  subtrahend
//  bin        in   1      borrow in (1 = subtract an extra 1)
//  out_valid  out  1      result fields valid
//  out_ready  in   1      consumer takes result this cycle
//  D          out  WIDTH  difference, modulo 2^WIDTH
//  bout       out  1      borrow out: 1 iff unsigned A < B + bin
//  OF         out  1      signed overflow
//  Z          out  1      D == 0
//  N          out  1      D[WIDTH-1]
// BEHAVIOUR
//  - Arithmetic: D = A + ~B + ~bin (carry-in = ~bin); bout = ~carry_out.
//    OF = (A[MSB]^B[MSB]) & (D[MSB]^A[MSB]). Z, N derived from final D.
//  - Stage 1 (regs s1_*): low sum L = A[H-1:0]+~B[H-1:0]+~bin, low carry c;
//    high candidates H0 (carry-in 0) and H1 (carry-in 1) with carries; A,B MSBs.
//  - Stage 2 (output regs): D = {c ? H1 : H0, L}; bout from selected carry.
//  - Valid bits s1_v, s2_v (= out_valid). Transfer in: in_valid & in_ready.
//    Transfer out: out_valid & out_ready.
//  - s2 loads when ~s2_v | out_ready; s1 advances into s2 when s1_v and s2 loads.
//  - in_ready = rst_n & (~s1_v | (~s2_v | out_ready)); combinational from regs
//    and out_ready only, never from in_valid.
//  - Latency: accepted operands appear on outputs 2 cycles later when not stalled.
//    Throughput 1 result/cycle with out_ready held high.
//  - Stall: while out_valid & ~out_ready, D/bout/OF/Z/N/out_valid hold stable.
//    Pipeline holds max 2 operations; no drop, no duplicate, order preserved.
//  - Simultaneous out transfer and s1 advance in one cycle: new result replaces
//    old in s2; s1 reloads from input if in_valid.
//  - Data regs load only on their stage's enable; values with valid low are don't-care
//    but forced to 0 on reset.
//  - Reset (rst_n low, any cycle incl. mid-stall): s1_v = s2_v = 0 at once,
//    out_valid = 0, in_ready = 0, D/bout/OF/Z/N = 0. In-flight ops discarded.
//    First cycle after release: in_ready = 1.
//  - No state machine beyond the two valid bits; no X on outputs after reset.
// TESTING (WIDTH=32, out_ready=1 unless noted)
//  1 A=5,B=3,bin=0 accepted cycle t -> out_valid at t+2, D=2, bout=0, OF=0, Z=0, N=0.
//  2 A=0,B=1,bin=0 -> D=FFFFFFFF, bout=1, N=1, OF=0; A=7,B=7 -> D=0, Z=1, bout=0.
//  3 A=80000000,B=1 -> D=7FFFFFFF, OF=1, bout=0; A=7FFFFFFF,B=FFFFFFFF -> D=80000000,
//    OF=1, bout=1, N=1.
//  4 A=00010000,B=00000001,bin=1 -> D=0000FFFE, bout=0 (borrow crosses split);
//    A=0,B=0,bin=1 -> D=FFFFFFFF, bout=1.
//  5 Stream 3 ops, out_ready=0 for 4 cycles -> 2 accepted, in_ready=0 holds 3rd,
//    outputs stable; release -> 3 results in order, no loss/dup; then 1000 random
//    back-to-back ops vs. reference model with random out_ready.
//  6 Assert rst_n=0 with 2 ops in flight and out_ready=0 -> out_valid=0, outputs 0
//    same cycle; after release in_ready=1, no stale result ever appears.

Source files
------------

// File: rtl/pipelined_select_subtractor.sv
// Two-stage carry-select subtractor D = A - B - bin with valid/ready handshake.
// Stage 1 resolves the low half and both high-half candidates; stage 2 selects.
module pipelined_select_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             bout,
  output logic             OF,
  output logic             Z,
  output logic             N
);

  localparam int H = WIDTH / 2;

  logic         s1_v_q, s1_v_d;
  logic [H-1:0] s1_lo_q;
  logic         s1_c_q;
  logic [H-1:0] s1_h0_q, s1_h1_q;
  logic         s1_h0c_q, s1_h1c_q;
  logic         s1_amsb_q, s1_bmsb_q;

  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] d_q;
  logic             bout_q, of_q, z_q, n_q;

  logic s1_ld, s1_take, s2_ld, s2_take;

  // Subtraction as A + ~B + ~bin; each sum is one bit wider to expose its carry.
  logic [H:0] lo_sum_d, h0_sum_d, h1_sum_d;

  assign lo_sum_d = {1'b0, A[H-1:0]} + {1'b0, ~B[H-1:0]} + {{H{1'b0}}, ~bin};
  assign h0_sum_d = {1'b0, A[WIDTH-1:H]} + {1'b0, ~B[WIDTH-1:H]};
  assign h1_sum_d = h0_sum_d + {{H{1'b0}}, 1'b1};

  assign s2_ld    = ~s2_v_q | out_ready;
  assign s2_take  = s2_ld & s1_v_q;
  assign s1_ld    = ~s1_v_q | s2_ld;
  assign in_ready = rst_n & s1_ld;
  assign s1_take  = in_valid & in_ready;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    s1_v_d = s1_v_q;
    s2_v_d = s2_v_q;
    if (s1_ld) s1_v_d = in_valid;
    if (s2_ld) s2_v_d = s1_v_q;
  end

  // Stage 2 selection: the registered low-half carry picks the high candidate.
  logic [H-1:0]     hi_sel_d;
  logic             hi_c_d;
  logic [WIDTH-1:0] d_d;

  assign hi_sel_d = s1_c_q ? s1_h1_q : s1_h0_q;
  assign hi_c_d   = s1_c_q ? s1_h1c_q : s1_h0c_q;
  assign d_d      = {hi_sel_d, s1_lo_q};

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
    end
  end

  // NOTE: data registers are reset too so the outputs are 0, never X, straight after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_lo_q   <= '0;
      s1_c_q    <= 1'b0;
      s1_h0_q   <= '0;
      s1_h0c_q  <= 1'b0;
      s1_h1_q   <= '0;
      s1_h1c_q  <= 1'b0;
      s1_amsb_q <= 1'b0;
      s1_bmsb_q <= 1'b0;
    end else if (s1_take) begin
      s1_lo_q   <= lo_sum_d[H-1:0];
      s1_c_q    <= lo_sum_d[H];
      s1_h0_q   <= h0_sum_d[H-1:0];
      s1_h0c_q  <= h0_sum_d[H];
      s1_h1_q   <= h1_sum_d[H-1:0];
      s1_h1c_q  <= h1_sum_d[H];
      s1_amsb_q <= A[WIDTH-1];
      s1_bmsb_q <= B[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q    <= '0;
      bout_q <= 1'b0;
      of_q   <= 1'b0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
    end else if (s2_take) begin
      d_q    <= d_d;
      bout_q <= ~hi_c_d;
      of_q   <= (s1_amsb_q ^ s1_bmsb_q) & (d_d[WIDTH-1] ^ s1_amsb_q);
      z_q    <= (d_d == '0);
      n_q    <= d_d[WIDTH-1];
    end
  end

  assign out_valid = s2_v_q;
  assign D         = d_q;
  assign bout      = bout_q;
  assign OF        = of_q;
  assign Z         = z_q;
  assign N         = n_q;

endmodule

// File: tb/tb_pipelined_select_subtractor.sv
// Self-checking bench: directed corner cases, stall/reset behaviour and a random
// stream scored against an arithmetic reference model.
module tb_pipelined_select_subtractor;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] D;
  logic         bout, OF, Z, N;

  pipelined_select_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .bout(bout), .OF(OF), .Z(Z), .N(N)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        bout;
    logic        of;
    logic        z;
    logic        n;
  } res_t;

  res_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_out = 0;
  bit          stalled = 1'b0;
  logic [35:0] held = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: plain wide and signed arithmetic on the operands.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic bi);
    res_t        r;
    logic [32:0] diff;
    longint      sd;
    diff   = {1'b0, a} - {1'b0, b} - {32'b0, bi};
    r.d    = diff[31:0];
    r.bout = ({32'b0, a} < ({32'b0, b} + {63'b0, bi}));
    sd     = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
    r.of   = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    r.z    = (r.d == 32'd0);
    r.n    = r.d[31];
    return r;
  endfunction

  function automatic logic [35:0] obs();
    return {D, bout, OF, Z, N};
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0001_0000 | ($urandom() & 32'h1);
      default: return $urandom();
    endcase
  endfunction

  // Scoreboard and stall-stability monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_hold", 64'(obs()), 64'(held));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_result", 64'(out_valid), 64'd0);
        else begin
          res_t e;
          e = sb.pop_front();
          check("result", 64'(obs()), 64'(e));
          n_out++;
        end
      end
      if (in_valid && in_ready) sb.push_back(model(A, B, bin));
      stalled = out_valid && !out_ready;
      held    = obs();
    end
  end

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic bi, input logic [31:0] ed, input logic [3:0] eflags);
    @(posedge clk); #1;
    A = a; B = b; bin = bi; in_valid = 1'b1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_not_yet"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_D"}, 64'(D), 64'(ed));
    check({tag, "_bout_of_z_n"}, 64'({bout, OF, Z, N}), 64'(eflags));
  endtask

  initial begin
    logic [35:0] snap;
    int          base;
    int          accepted;
    int          cyc;
    bit          fire;

    #12;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_outputs", 64'(obs()), 64'd0);
    #1 rst_n = 1'b1;
    #1 check("release_in_ready", 64'(in_ready), 64'd1);

    directed("sub5_3",     32'd5,          32'd3,          1'b0, 32'd2,          4'b0000);
    directed("zero_m1",    32'd0,          32'd1,          1'b0, 32'hFFFF_FFFF,  4'b1001);
    directed("eq7",        32'd7,          32'd7,          1'b0, 32'd0,          4'b0010);
    directed("ovf_neg",    32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF,  4'b0100);
    directed("ovf_pos",    32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  4'b1101);
    directed("split_brw",  32'h0001_0000,  32'd1,          1'b1, 32'h0000_FFFE,  4'b0000);
    directed("bin_only",   32'd0,          32'd0,          1'b1, 32'hFFFF_FFFF,  4'b1001);

    // Three ops against a stalled consumer: two fit, the third is held off.
    @(posedge clk); #1;
    out_ready = 1'b0;
    base = n_out;
    A = 32'd10; B = 32'd3; bin = 1'b0; in_valid = 1'b1;
    check("stall_acc1", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    A = 32'd20; B = 32'd5; bin = 1'b1;
    check("stall_acc2", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    A = 32'd30; B = 32'd40; bin = 1'b0;
    check("stall_full", 64'(in_ready), 64'd0);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    snap = obs();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_block", 64'(in_ready), 64'd0);
      check("stall_stable", 64'(obs()), 64'(snap));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stall_count", 64'(n_out - base), 64'd3);
    check("stall_drained", 64'(sb.size()), 64'd0);

    // Random back-to-back stream with random backpressure.
    accepted = 0;
    cyc = 0;
    while (accepted < 1000 && cyc < 20000) begin
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (fire) accepted++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || fire) begin
        in_valid = (accepted < 1000) && ($urandom_range(0, 4) != 0);
        A = rnd32();
        B = rnd32();
        bin = 1'($urandom_range(0, 1));
      end
    end
    in_valid = 1'b0;
    check("rand_accepted", 64'(accepted), 64'd1000);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    check("rand_drained", 64'(sb.size()), 64'd0);

    // Reset with two ops in flight and the consumer stalled.
    @(posedge clk); #1;
    out_ready = 1'b0;
    A = 32'd100; B = 32'd1; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    A = 32'd200; B = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("inflight_valid", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_outputs", 64'(obs()), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1 check("rst_release_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("no_stale", 64'(out_valid), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
